// File: rtl/bf16_block_align_encoder.sv
// Block-floating-point front end: gathers N BF16 operands, finds the shared
// max exponent and streams each operand as a two's-complement mantissa aligned to it.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_data (BF16 operand in);
//        out_valid/out_ready, out_mant, out_exp, out_idx, out_last, out_special (aligned element out).
module bf16_block_align_encoder #(
    parameter int N     = 2,
    parameter int OUT_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_mant,
    output logic [7:0]           out_exp,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_special
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        COLLECT,
        ALIGN,
        EMIT
    } state_t;

    state_t          state;
    logic [15:0]     op_buf [N];
    logic [IW-1:0]   wr_cnt;
    logic [7:0]      max_exp;
    logic            special;
    logic [IW-1:0]   nxt_idx;
    logic [7:0]      in_exp;

    assign in_ready = (state == COLLECT);
    assign nxt_idx  = out_idx + 1'b1;
    assign in_exp   = in_data[14:7];

    // Denormals flush to zero; shifts of OUT_W-1 or more leave nothing, so the
    // result is forced to zero and the sign is naturally lost.
    function automatic logic [OUT_W-1:0] encode(input logic [15:0] op,
                                                input logic [7:0]  mx);
        logic [7:0]       mag;
        logic [7:0]       d;
        logic [OUT_W-2:0] a;
        mag = (op[14:7] == 8'd0) ? 8'd0 : {1'b1, op[6:0]};
        d   = mx - op[14:7];
        if (d >= 8'(OUT_W - 1))
            a = '0;
        else
            a = {mag, {(OUT_W - 9){1'b0}}} >> d;
        encode = op[15] ? -{1'b0, a} : {1'b0, a};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= COLLECT;
            wr_cnt      <= '0;
            max_exp     <= '0;
            special     <= 1'b0;
            out_valid   <= 1'b0;
            out_mant    <= '0;
            out_exp     <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            out_special <= 1'b0;
            for (int i = 0; i < N; i++)
                op_buf[i] <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (in_valid) begin
                        op_buf[wr_cnt] <= in_data;
                        if (in_exp > max_exp)
                            max_exp <= in_exp;
                        if (in_exp == 8'hFF)
                            special <= 1'b1;
                        if (wr_cnt == LAST) begin
                            wr_cnt <= '0;
                            state  <= ALIGN;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    out_mant    <= encode(op_buf[0], max_exp);
                    out_exp     <= max_exp;
                    out_idx     <= '0;
                    out_last    <= 1'b0;
                    out_special <= special;
                    out_valid   <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_idx == LAST) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            max_exp   <= '0;
                            special   <= 1'b0;
                            state     <= COLLECT;
                        end else begin
                            out_mant <= encode(op_buf[nxt_idx], max_exp);
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_idx == LAST);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_block_align_encoder.sv
// Directed testbench for bf16_block_align_encoder (N=2, OUT_W=12).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_bf16_block_align_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_mant;
    logic [7:0]  out_exp;
    logic [0:0]  out_idx;
    logic        out_last;
    logic        out_special;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bf16_block_align_encoder #(.N(2), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_idx(out_idx),
        .out_last(out_last), .out_special(out_special)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] op);
        int n = 0;
        in_valid = 1'b1;
        in_data  = op;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop(output logic [11:0] m, output logic [7:0] e,
                       output logic i, output logic l, output logic s);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL pop_timeout: out_valid=%0b required 1", out_valid);
        end
        m = out_mant;
        e = out_exp;
        i = out_idx[0];
        l = out_last;
        s = out_special;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, out_mant, out_exp, out_idx, out_last, out_special}
            !== {1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b v=%0b m=%h e=%h i=%0d l=%0b s=%0b required rdy=1 rest 0",
                     in_ready, out_valid, out_mant, out_exp, out_idx, out_last, out_special);
        end
    endtask

    task automatic test_basic();
        send(16'h3F80);
        send(16'h4000);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL align_cycle: v=%0b rdy=%0b required 0 0", out_valid, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_idx, out_mant, out_exp, out_last} !== {1'b1, 1'b0, 12'h200, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL basic_e0: v=%0b i=%0d m=%h e=%h l=%0b required 1 0 200 80 0",
                     out_valid, out_idx, out_mant, out_exp, out_last);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_idx, out_mant, out_exp, out_last} !== {1'b1, 1'b1, 12'h400, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL basic_e1: v=%0b i=%0d m=%h e=%h l=%0b required 1 1 400 80 1",
                     out_valid, out_idx, out_mant, out_exp, out_last);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: v=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_negative();
        logic [11:0] m0, m1;
        logic [7:0]  e0, e1;
        logic        i0, i1, l0, l1, s0, s1;
        send(16'hBFC0);
        send(16'h3F80);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, e0, i0, l0} !== {12'hA00, 8'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL neg_e0: m=%h e=%h i=%0d l=%0b required a00 7f 0 0", m0, e0, i0, l0);
        end
        checks++;
        if ({m1, e1, i1, l1} !== {12'h400, 8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL neg_e1: m=%h e=%h i=%0d l=%0b required 400 7f 1 1", m1, e1, i1, l1);
        end
    endtask

    task automatic test_boundaries();
        logic [11:0] m0, m1;
        logic [7:0]  e0, e1;
        logic        i0, i1, l0, l1, s0, s1;
        send(16'h4780);
        send(16'h3F80);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, m1, e0, e1} !== {12'h400, 12'h000, 8'h8F, 8'h8F}) begin
            errors++;
            $display("FAIL far_shift: m0=%h m1=%h e=%h/%h required 400 000 8f", m0, m1, e0, e1);
        end
        send(16'h0000);
        send(16'h8000);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, m1, e0, e1, s0, s1} !== {12'h0, 12'h0, 8'h0, 8'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zero_block: m0=%h m1=%h e=%h/%h s=%0b%0b required all 0",
                     m0, m1, e0, e1, s0, s1);
        end
        send(16'h7F80);
        send(16'h3F80);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, m1, e0, e1, s0, s1} !== {12'h400, 12'h000, 8'hFF, 8'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL special: m0=%h m1=%h e=%h/%h s=%0b%0b required 400 000 ff 11",
                     m0, m1, e0, e1, s0, s1);
        end
        send(16'h3F80);
        send(16'h3F80);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({s0, s1, e0, m0, m1} !== {1'b0, 1'b0, 8'h7F, 12'h400, 12'h400}) begin
            errors++;
            $display("FAIL special_clear: s=%0b%0b e=%h m=%h/%h required 00 7f 400 400",
                     s0, s1, e0, m0, m1);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] m0, m1;
        logic [7:0]  e0, e1;
        logic        i0, i1, l0, l1, s0, s1;
        logic [11:0] hm;
        logic        bad = 1'b0;
        int          n = 0;
        send(16'h3F80);
        send(16'h4000);
        out_ready = 1'b0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        hm = out_mant;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_valid !== 1'b1 || out_mant !== hm || out_idx !== 1'b0 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad || hm !== 12'h200) begin
            errors++;
            $display("FAIL stall_stable: m=%h now=%h v=%0b rdy=%0b required 200 held, v=1 rdy=0",
                     hm, out_mant, out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_idx !== 1'b1 || out_mant !== 12'h400) begin
            errors++;
            $display("FAIL stall_e1: i=%0d m=%h required 1 400", out_idx, out_mant);
        end
        in_valid = 1'b1;
        in_data  = 16'hBFC0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: rdy=%0b v=%0b required 1 0", in_ready, out_valid);
        end
        tick();
        in_data = 16'h3F80;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: rdy=%0b required 0", in_ready);
        end
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, m1, e0} !== {12'hA00, 12'h400, 8'h7F}) begin
            errors++;
            $display("FAIL b2b_block: m0=%h m1=%h e=%h required a00 400 7f", m0, m1, e0);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] m0, m1;
        logic [7:0]  e0, e1;
        logic        i0, i1, l0, l1, s0, s1;
        send(16'h7F80);
        send(16'h4780);
        pop(m0, e0, i0, l0, s0);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 1'b1 || s0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: v=%0b i=%0d s=%0b required 1 1 1", out_valid, out_idx, s0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_special !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: v=%0b rdy=%0b s=%0b required 0 1 0", out_valid, in_ready, out_special);
        end
        send(16'h4000);
        send(16'hBF80);
        pop(m0, e0, i0, l0, s0);
        pop(m1, e1, i1, l1, s1);
        checks++;
        if ({m0, m1, e0, s0, s1, l0, l1} !== {12'h400, 12'hE00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fresh_block: m0=%h m1=%h e=%h s=%0b%0b l=%0b%0b required 400 e00 80 00 01",
                     m0, m1, e0, s0, s1, l0, l1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
